arb_fifo_ctrl: RTL and testbench
================================

ARB_FIFO_CTRL -- requirements
Module: arb_fifo_ctrl

Interface
REQ-001 Parameter: width, default 8, data bits per request (legal range 1..64).
REQ-002 Port: CLK  input  1  rising-edge clock.
REQ-003 Port: RST_N  input  1  reset, synchronous, active-low.
REQ-004 Port: REQ  input  4  per-requester enqueue request, bit i = requester i.
REQ-005 Port: REQ_DATA0..REQ_DATA3  input  width each  requester payloads.
REQ-006 Port: GRANT  output  4  combinational one-hot grant, or all-zero.
REQ-007 Port: RESET  input  1  logical-cycle boundary pulse; clears per-requester consumed state, not data.
REQ-008 Port: CONSUMED  output  4  bit i = requester i already enqueued this logical cycle.
REQ-009 Port: NOT_EMPTY  output  1  queue holds at least one entry.
REQ-010 Port: DEQ_VALUE  output  width  head entry payload; value undefined when empty.
REQ-011 Port: DEQ  input  1  pop head this cycle; ignored when NOT_EMPTY=0.
REQ-012 Port: COUNT  output  2  occupancy 0..2.

Function
REQ-013 Queue SHALL be 2 entries deep, in-order, no bypass: an entry granted in cycle t SHALL appear at NOT_EMPTY/DEQ_VALUE in cycle t+1.
REQ-014 Eligible set SHALL be REQ & ~CONSUMED.
REQ-015 Space SHALL be available when COUNT<2, or COUNT==2 with DEQ=1 (pipelined enq/deq when full).
REQ-016 GRANT SHALL be nonzero only when space is available and the eligible set is nonzero.
REQ-017 Grant selection SHALL be round-robin: highest priority is the pointer value P (0..3), searching P, P+1, ... modulo 4.
REQ-018 On a grant to requester g, P SHALL become (g+1) mod 4 at the next edge; otherwise P SHALL hold.
REQ-019 On a grant to g, REQ_DATAg SHALL be written at the tail and CONSUMED[g] SHALL set at the next edge.
REQ-020 At most one grant per cycle; each requester at most one grant per logical cycle.
REQ-021 RESET=1 SHALL clear all CONSUMED bits at the next edge, taking priority over a same-cycle set; the same-cycle grant and its enqueue SHALL still occur.
REQ-022 COUNT next = COUNT + enq - (DEQ & NOT_EMPTY); simultaneous enq and deq SHALL leave COUNT unchanged and preserve order.
REQ-023 DEQ at COUNT==0 SHALL not change state; no underflow.
REQ-024 REQ deasserted without a grant SHALL not alter P or CONSUMED.

Reset
REQ-025 RST_N=0 at an edge SHALL force COUNT=0, NOT_EMPTY=0, CONSUMED=4'b0000, P=0; GRANT SHALL be 4'b0000 while RST_N=0.
REQ-026 Reset mid-operation SHALL discard queued entries; no DEQ_VALUE reset value required.
REQ-027 Same values SHALL apply via initial state for simulation.

Structure
REQ-028 Shared package SHALL hold constants N_REQ=4, DEPTH=2, pointer width 2.
REQ-029 Round-robin selection SHALL be a combinational sub-module rr_arb4 (inputs eligible mask, pointer; output one-hot grant).
REQ-030 Storage SHALL be two width-bit registers with 1-bit head/tail pointers; no RAM.

Verification
REQ-031 Reset, then REQ=4'b1111 with data 0xA0..0xA3, DEQ=1 continuously -> GRANT 0001,0010,0100,1000 on successive cycles, DEQ_VALUE sequence A0,A1,A2,A3, then GRANT=0 until RESET.
REQ-032 DEQ=0, REQ=4'b0011 held -> two grants (0001 then 0010), COUNT=2, GRANT=0 thereafter; assert DEQ -> COUNT stays 2 only if a new eligible requester exists, else drops to 1.
REQ-033 COUNT=2, REQ=4'b0100, DEQ=1 same cycle -> GRANT=0100, COUNT stays 2, head advances, order preserved.
REQ-034 RESET=1 in the cycle requester 2 is granted -> entry enqueued, CONSUMED[2]=0 next cycle, requester 2 eligible again.
REQ-035 P=3, REQ=4'b1001 -> GRANT=1000, P=0 next; next cycle GRANT=0001.
REQ-036 RST_N=0 with COUNT=2 and CONSUMED=1111 -> next cycle COUNT=0, NOT_EMPTY=0, CONSUMED=0, first subsequent grant to requester 0 when REQ=1111.

Source files
------------

// File: rtl/arb_fifo_ctrl_pkg.sv
// Shared constants, types and helpers for the round-robin arbiter feeding a 2-entry queue.
package arb_fifo_ctrl_pkg;

  localparam int N_REQ = 4;
  localparam int DEPTH = 2;
  localparam int PTR_W = 2;

  typedef logic [N_REQ-1:0]            req_vec_t;
  typedef logic [PTR_W-1:0]            rr_ptr_t;
  typedef logic [$clog2(DEPTH+1)-1:0]  cnt_t;

  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

  function automatic rr_ptr_t onehot_idx(input req_vec_t oh);
    rr_ptr_t idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = rr_ptr_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_fifo_ctrl_if.sv
// Request/grant and dequeue signals between the requesters, the consumer and arb_fifo_ctrl.
interface arb_fifo_ctrl_if
  import arb_fifo_ctrl_pkg::*;
  #(parameter int width = 8);

  req_vec_t         REQ;
  logic [width-1:0] REQ_DATA0;
  logic [width-1:0] REQ_DATA1;
  logic [width-1:0] REQ_DATA2;
  logic [width-1:0] REQ_DATA3;
  req_vec_t         GRANT;
  logic             RESET;
  req_vec_t         CONSUMED;
  logic             NOT_EMPTY;
  logic [width-1:0] DEQ_VALUE;
  logic             DEQ;
  cnt_t             COUNT;

  modport master (
    output REQ, REQ_DATA0, REQ_DATA1, REQ_DATA2, REQ_DATA3, RESET, DEQ,
    input  GRANT, CONSUMED, NOT_EMPTY, DEQ_VALUE, COUNT
  );

  modport slave (
    input  REQ, REQ_DATA0, REQ_DATA1, REQ_DATA2, REQ_DATA3, RESET, DEQ,
    output GRANT, CONSUMED, NOT_EMPTY, DEQ_VALUE, COUNT
  );

endinterface

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin picker: first eligible bit searching up from ptr, modulo 4.
// Latency: none; no backpressure of its own, the caller masks the result when there is no space.
module rr_arb4
  import arb_fifo_ctrl_pkg::*;
(
  input  req_vec_t elig,
  input  rr_ptr_t  ptr,
  output req_vec_t grant
);

  always_comb begin
    rr_ptr_t idx;
    logic    found;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    // rr_ptr_t is exactly log2(N_REQ) bits, so the add wraps modulo N_REQ
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr + rr_ptr_t'(i);
      if (!found && elig[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_fifo_ctrl.sv
// Round-robin arbiter granting one requester per cycle into a 2-entry in-order queue.
// Latency: granted entry visible at the head one cycle later; grants stall while full unless DEQ frees a slot.
module arb_fifo_ctrl
  import arb_fifo_ctrl_pkg::*;
  #(parameter int width = 8)
(
  input  logic            CLK,
  input  logic            RST_N,
  arb_fifo_ctrl_if.slave  bus
);

  cnt_t             count;
  logic             head;
  logic             tail;
  logic [width-1:0] slot0;
  logic [width-1:0] slot1;
  req_vec_t         consumed;
  rr_ptr_t          ptr;

  req_vec_t         elig;
  req_vec_t         rr_grant;
  req_vec_t         grant;
  rr_ptr_t          gidx;
  logic             space;
  logic             enq;
  logic             deq_fire;
  logic [width-1:0] enq_data;

  assign elig = bus.REQ & ~consumed;
  // DEQ at full implies non-empty, so the head slot is freed at this same edge
  assign space = (count != FULL_CNT) || bus.DEQ;

  rr_arb4 u_rr_arb4 (
    .elig  (elig),
    .ptr   (ptr),
    .grant (rr_grant)
  );

  assign grant    = (RST_N && space) ? rr_grant : '0;
  assign enq      = |grant;
  assign deq_fire = bus.DEQ && (count != '0);
  assign gidx     = onehot_idx(grant);

  always_comb begin
    enq_data = bus.REQ_DATA0;
    case (gidx)
      2'd1:    enq_data = bus.REQ_DATA1;
      2'd2:    enq_data = bus.REQ_DATA2;
      2'd3:    enq_data = bus.REQ_DATA3;
      default: enq_data = bus.REQ_DATA0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      count    <= '0;
      head     <= 1'b0;
      tail     <= 1'b0;
      consumed <= '0;
      ptr      <= '0;
    end else begin
      if (enq) begin
        tail <= ~tail;
        ptr  <= gidx + 1'b1;
      end
      if (deq_fire) head <= ~head;
      case ({enq, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      consumed <= bus.RESET ? '0 : (consumed | grant);
    end
  end

  // Payload slots carry no reset; they are only observed while count is non-zero
  always_ff @(posedge CLK) begin
    if (enq) begin
      if (tail) slot1 <= enq_data;
      else      slot0 <= enq_data;
    end
  end

  assign bus.GRANT     = grant;
  assign bus.CONSUMED  = consumed;
  assign bus.NOT_EMPTY = (count != '0);
  assign bus.DEQ_VALUE = head ? slot1 : slot0;
  assign bus.COUNT     = count;

endmodule

// File: tb/tb_arb_fifo_ctrl.sv
// Directed bench for arb_fifo_ctrl: stimulus queues expected grants/payloads, a negedge monitor checks them.
module tb_arb_fifo_ctrl;

  logic CLK;
  logic RST_N;

  arb_fifo_ctrl_if #(.width(8)) bus ();

  arb_fifo_ctrl #(.width(8)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp_grant[$];
  logic [7:0] exp_data[$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; eg/ed are the grant and payload expected to result (eg=0: no grant)
  task automatic cyc(input logic [3:0] req, input logic deq, input logic rs,
                     input logic [3:0] eg, input logic [7:0] ed);
    if (eg != 4'b0000) begin
      exp_grant.push_back(eg);
      exp_data.push_back(ed);
    end
    bus.REQ   = req;
    bus.DEQ   = deq;
    bus.RESET = rs;
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      if (bus.GRANT != 4'b0000) begin
        if (exp_grant.size() == 0) check("grant_unexpected", 64'(bus.GRANT), 64'd0);
        else                       check("grant", 64'(bus.GRANT), 64'(exp_grant.pop_front()));
      end
      if (bus.DEQ && bus.NOT_EMPTY) begin
        if (exp_data.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL deq_unexpected: got %0h, expected no entry", bus.DEQ_VALUE);
        end else begin
          check("deq_value", 64'(bus.DEQ_VALUE), 64'(exp_data.pop_front()));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end within budget");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N         = 1'b0;
    bus.REQ       = 4'b1111;
    bus.DEQ       = 1'b0;
    bus.RESET     = 1'b0;
    bus.REQ_DATA0 = 8'hA0;
    bus.REQ_DATA1 = 8'hA1;
    bus.REQ_DATA2 = 8'hA2;
    bus.REQ_DATA3 = 8'hA3;
    @(posedge CLK); #1;
    check("grant_in_reset", 64'(bus.GRANT), 64'd0);
    @(posedge CLK); #1;
    bus.REQ = 4'b0000;
    RST_N   = 1'b1;
    check("reset_count", 64'(bus.COUNT), 64'd0);
    check("reset_not_empty", 64'(bus.NOT_EMPTY), 64'd0);
    check("reset_consumed", 64'(bus.CONSUMED), 64'd0);

    // All four requesting with continuous DEQ: one pass of the ring, then silence
    cyc(4'b1111, 1'b1, 1'b0, 4'b0001, 8'hA0);
    cyc(4'b1111, 1'b1, 1'b0, 4'b0010, 8'hA1);
    cyc(4'b1111, 1'b1, 1'b0, 4'b0100, 8'hA2);
    cyc(4'b1111, 1'b1, 1'b0, 4'b1000, 8'hA3);
    for (int i = 0; i < 3; i++) cyc(4'b1111, 1'b1, 1'b0, 4'b0000, 8'h00);
    check("s1_consumed", 64'(bus.CONSUMED), 64'hF);
    check("s1_no_underflow", 64'(bus.COUNT), 64'd0);
    cyc(4'b0000, 1'b0, 1'b1, 4'b0000, 8'h00);
    check("s1_reset_consumed", 64'(bus.CONSUMED), 64'd0);

    // Fill to full with no DEQ, then DEQ with nobody eligible
    cyc(4'b0011, 1'b0, 1'b0, 4'b0001, 8'hA0);
    cyc(4'b0011, 1'b0, 1'b0, 4'b0010, 8'hA1);
    cyc(4'b0011, 1'b0, 1'b0, 4'b0000, 8'h00);
    cyc(4'b0011, 1'b0, 1'b0, 4'b0000, 8'h00);
    check("s2_full_count", 64'(bus.COUNT), 64'd2);
    check("s2_consumed", 64'(bus.CONSUMED), 64'h3);
    cyc(4'b0011, 1'b1, 1'b0, 4'b0000, 8'h00);
    check("s2_drop_count", 64'(bus.COUNT), 64'd1);

    // Refill, then enqueue and dequeue together while full
    cyc(4'b1000, 1'b0, 1'b0, 4'b1000, 8'hA3);
    check("s3_full_count", 64'(bus.COUNT), 64'd2);
    cyc(4'b0100, 1'b1, 1'b0, 4'b0100, 8'hA2);
    check("s3_pipelined_count", 64'(bus.COUNT), 64'd2);
    check("s3_consumed", 64'(bus.CONSUMED), 64'hF);
    check("s3_not_empty", 64'(bus.NOT_EMPTY), 64'd1);

    // Pointer sits at 3: requester 3 wins over 0, then 0
    cyc(4'b0000, 1'b1, 1'b1, 4'b0000, 8'h00);
    check("s4_consumed_clear", 64'(bus.CONSUMED), 64'd0);
    check("s4_count", 64'(bus.COUNT), 64'd1);
    cyc(4'b1001, 1'b1, 1'b0, 4'b1000, 8'hA3);
    cyc(4'b1001, 1'b1, 1'b0, 4'b0001, 8'hA0);
    cyc(4'b0000, 1'b1, 1'b0, 4'b0000, 8'h00);
    check("s4_count_empty", 64'(bus.COUNT), 64'd0);
    check("s4_consumed", 64'(bus.CONSUMED), 64'h9);

    // RESET in the same cycle as a grant: enqueue happens, consumed bit does not stick
    cyc(4'b0100, 1'b0, 1'b1, 4'b0100, 8'hA2);
    check("s5_consumed_cleared", 64'(bus.CONSUMED), 64'd0);
    check("s5_count", 64'(bus.COUNT), 64'd1);
    cyc(4'b0100, 1'b0, 1'b0, 4'b0100, 8'hA2);
    check("s5_consumed_regrant", 64'(bus.CONSUMED), 64'h4);
    check("s5_count_full", 64'(bus.COUNT), 64'd2);

    // Reach full with everyone consumed, then reset mid-operation
    cyc(4'b1011, 1'b1, 1'b0, 4'b1000, 8'hA3);
    cyc(4'b1011, 1'b1, 1'b0, 4'b0001, 8'hA0);
    cyc(4'b1011, 1'b1, 1'b0, 4'b0010, 8'hA1);
    check("s6_count", 64'(bus.COUNT), 64'd2);
    check("s6_consumed", 64'(bus.CONSUMED), 64'hF);
    RST_N   = 1'b0;
    bus.REQ = 4'b1111;
    bus.DEQ = 1'b0;
    exp_data.delete();
    #1;
    check("s6_grant_in_reset", 64'(bus.GRANT), 64'd0);
    @(posedge CLK); #1;
    bus.REQ = 4'b0000;
    RST_N   = 1'b1;
    check("s6_reset_count", 64'(bus.COUNT), 64'd0);
    check("s6_reset_not_empty", 64'(bus.NOT_EMPTY), 64'd0);
    check("s6_reset_consumed", 64'(bus.CONSUMED), 64'd0);
    cyc(4'b1111, 1'b1, 1'b0, 4'b0001, 8'hA0);
    cyc(4'b0000, 1'b1, 1'b0, 4'b0000, 8'h00);
    cyc(4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00);
    check("final_count", 64'(bus.COUNT), 64'd0);
    check("pending_grants", 64'(exp_grant.size()), 64'd0);
    check("pending_data", 64'(exp_data.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
